// File: rtl/uch_burst_arb.sv
// rtl/uch_burst_arb.sv - round-robin burst sequencer sharing one up counter between requesters
module uch_burst_arb #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4
) (
    input  logic                       uba_clk,
    input  logic                       uba_rst,
    input  logic [NUM_REQ-1:0]         uba_req,
    input  logic [NUM_REQ*CNT_W-1:0]   uba_len,
    input  logic                       uba_hold,
    input  logic [CNT_W-1:0]           uba_cnt_val,
    output logic                       uba_cnt_rst,
    output logic                       uba_cnt_en,
    output logic [NUM_REQ-1:0]         uba_gnt,
    output logic [NUM_REQ-1:0]         uba_done,
    output logic [NUM_REQ-1:0]         uba_abrt,
    output logic                       uba_busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_done;
    logic [NUM_REQ-1:0]   r_abrt;
    logic [IDX_W-1:0]     r_ptr;
    logic [CNT_W-1:0]     r_len;
    logic                 r_clr;
    logic                 r_busy;

    logic [CNT_W-1:0]     w_len_arr [NUM_REQ];
    logic                 w_found;
    logic [IDX_W-1:0]     w_pick;
    logic [NUM_REQ-1:0]   w_pick_oh;
    logic                 w_req_g;
    logic                 w_run;
    logic                 w_at_len;

    // Unpack the per-requester burst lengths so the winner's length is a plain array read
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_len
            assign w_len_arr[gi] = uba_len[gi*CNT_W +: CNT_W];
        end
    endgenerate

    // Round-robin scan starting just after the last granted requester, wrapping around
    always_comb begin
        int               w_pos;
        logic [IDX_W-1:0] w_idx;
        w_found   = 1'b0;
        w_pick    = '0;
        w_pick_oh = '0;
        w_pos     = 0;
        w_idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = int'(r_ptr) + 1 + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            w_idx = IDX_W'(w_pos);
            if (!w_found && uba_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
        w_pick_oh[w_pick] = w_found;
    end

    // The granted requester still asserting its request; losing it during RUN aborts the burst
    assign w_req_g  = |(uba_req & r_gnt);
    assign w_run    = (r_state == ST_RUN);
    assign w_at_len = (uba_cnt_val == r_len);

    // Counter enable is combinational so hold, abort and terminal count gate the very same cycle
    assign uba_cnt_en  = w_run && !uba_hold && w_req_g && !w_at_len;
    assign uba_cnt_rst = uba_rst | r_clr;

    assign uba_gnt  = r_gnt;
    assign uba_done = r_done;
    assign uba_abrt = r_abrt;
    assign uba_busy = r_busy;

    // Burst sequencer: arbitrate, clear the counter, run to length or abort, then pulse completion
    always_ff @(posedge uba_clk or posedge uba_rst) begin
        if (uba_rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_abrt  <= '0;
            r_ptr   <= IDX_W'(NUM_REQ - 1);
            r_len   <= '0;
            r_clr   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state <= ST_CLEAR;
                        r_gnt   <= w_pick_oh;
                        r_len   <= w_len_arr[w_pick];
                        r_ptr   <= w_pick;
                        r_clr   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_clr   <= 1'b0;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    // A dropped request wins over both terminal count and hold
                    if (!w_req_g) begin
                        r_state <= ST_ABORT;
                        r_abrt  <= r_gnt;
                    end else if (w_at_len) begin
                        r_state <= ST_DONE;
                        r_done  <= r_gnt;
                    end
                end
                ST_DONE, ST_ABORT: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                    r_done  <= '0;
                    r_abrt  <= '0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                    r_done  <= '0;
                    r_abrt  <= '0;
                    r_clr   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uch_burst_arb.sv
// tb/tb_uch_burst_arb.sv - self-checking bench for uch_burst_arb with a shared counter model
module tb_uch_burst_arb;

    localparam int N = 4;
    localparam int W = 4;

    logic           uba_clk = 1'b0;
    logic           uba_rst = 1'b1;
    logic [N-1:0]   uba_req = '0;
    logic [N*W-1:0] uba_len = '0;
    logic           uba_hold = 1'b0;
    logic [W-1:0]   cnt_val;
    logic           uba_cnt_rst;
    logic           uba_cnt_en;
    logic [N-1:0]   uba_gnt;
    logic [N-1:0]   uba_done;
    logic [N-1:0]   uba_abrt;
    logic           uba_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int last_g = N - 1;

    uch_burst_arb #(.NUM_REQ(N), .CNT_W(W)) dut (
        .uba_clk     (uba_clk),
        .uba_rst     (uba_rst),
        .uba_req     (uba_req),
        .uba_len     (uba_len),
        .uba_hold    (uba_hold),
        .uba_cnt_val (cnt_val),
        .uba_cnt_rst (uba_cnt_rst),
        .uba_cnt_en  (uba_cnt_en),
        .uba_gnt     (uba_gnt),
        .uba_done    (uba_done),
        .uba_abrt    (uba_abrt),
        .uba_busy    (uba_busy)
    );

    always #5 uba_clk = ~uba_clk;

    // shared up counter: async clear, counts while enabled
    always @(posedge uba_clk or posedge uba_cnt_rst) begin
        if (uba_cnt_rst) cnt_val <= '0;
        else if (uba_cnt_en) cnt_val <= cnt_val + 1'b1;
    end

    typedef struct {
        logic [N-1:0]   req;
        logic [N*W-1:0] len;
        int             hold_after;
        int             hold_cyc;
        int             abort_after;
        int             exp_g;
        int             exp_en;
        int             exp_busy;
        bit             exp_abrt;
    } vec_t;

    task automatic chk(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Drive one burst request and observe it until the controller returns to idle
    task automatic run_burst(input logic [N-1:0] req, input logic [N*W-1:0] len,
                             input int hold_after, input int hold_cyc, input int abort_after,
                             output int o_lat, output int o_g, output int o_en, output int o_busy,
                             output int o_clr, output int o_gbad, output logic [N-1:0] o_done,
                             output logic [N-1:0] o_abrt, output int o_npulse, output int o_cnt);
        int           it = 0;
        bit           seen = 0;
        bit           dropped = 0;
        bit           hstarted = 0;
        int           hleft = hold_cyc;
        logic [N-1:0] g_oh = '0;
        o_lat = -1; o_g = -1; o_en = 0; o_busy = 0; o_clr = 0; o_gbad = 0;
        o_done = '0; o_abrt = '0; o_npulse = 0; o_cnt = -1;
        uba_req  = req;
        uba_len  = len;
        uba_hold = 1'b0;
        while (it < 100) begin
            @(posedge uba_clk);
            #1;
            it++;
            uba_hold = 1'b0;
            if (seen && o_busy >= 1) begin
                if (abort_after >= 0 && !dropped && o_en == abort_after) begin
                    uba_req = uba_req & ~g_oh;
                    dropped = 1;
                end
                if (hold_after >= 0 && hleft > 0 && (hstarted || o_en == hold_after)) begin
                    uba_hold = 1'b1;
                    hstarted = 1;
                    hleft--;
                end
            end
            #1;
            if (uba_busy) begin
                if (!seen) begin
                    seen  = 1;
                    o_lat = it;
                    g_oh  = uba_gnt;
                    if ($countones(uba_gnt) == 1) begin
                        for (int i = 0; i < N; i++) if (uba_gnt[i]) o_g = i;
                    end
                    uba_len = ~len;
                end
                o_busy++;
                if (uba_gnt !== g_oh) o_gbad++;
                if (uba_cnt_rst) o_clr++;
            end else if (uba_gnt != '0) begin
                o_gbad++;
            end
            if (uba_cnt_en) o_en++;
            o_done = o_done | uba_done;
            o_abrt = o_abrt | uba_abrt;
            if (uba_done != '0 || uba_abrt != '0) o_npulse++;
            if (seen && !uba_busy) break;
        end
        if (!seen || uba_busy) begin
            chk("burst_timeout", it, -1);
        end
        o_cnt    = int'(cnt_val);
        uba_req  = '0;
        uba_hold = 1'b0;
    endtask

    task automatic apply_vec(input string tag, input vec_t v);
        int lat, g, en, busy, clr, gbad, npulse, cnt;
        logic [N-1:0] dn, ab;
        logic [N-1:0] exp_oh;
        run_burst(v.req, v.len, v.hold_after, v.hold_cyc, v.abort_after,
                  lat, g, en, busy, clr, gbad, dn, ab, npulse, cnt);
        exp_oh = '0;
        exp_oh[v.exp_g] = 1'b1;
        chk({tag, " grant_latency"}, lat, 1);
        chk({tag, " grant_index"}, g, v.exp_g);
        chk({tag, " en_cycles"}, en, v.exp_en);
        chk({tag, " cnt_final"}, cnt, v.exp_en);
        chk({tag, " busy_cycles"}, busy, v.exp_busy);
        chk({tag, " clr_cycles"}, clr, 1);
        chk({tag, " gnt_stable"}, gbad, 0);
        chk({tag, " done_mask"}, dn, v.exp_abrt ? 0 : exp_oh);
        chk({tag, " abrt_mask"}, ab, v.exp_abrt ? exp_oh : 0);
        chk({tag, " pulse_cycles"}, npulse, 1);
        last_g = v.exp_g;
    endtask

    vec_t tbl[10];

    initial begin
        int n_en;
        logic [N-1:0] acc_pulse;
        int acc_busy;
        vec_t v;

        //            req      len       h_aft h_cyc abort g  en busy abrt
        tbl[0] = '{4'b0001, 16'hA7C5, -1, 0, -1, 0, 5,  8,  1'b0};
        tbl[1] = '{4'b0100, 16'h30F1, -1, 0, -1, 2, 0,  3,  1'b0};
        tbl[2] = '{4'b0010, 16'h4396, -1, 0,  3, 1, 3,  6,  1'b1};
        tbl[3] = '{4'b0001, 16'hFFF6,  2, 4, -1, 0, 6,  13, 1'b0};
        tbl[4] = '{4'b1000, 16'hF123, -1, 0, -1, 3, 15, 18, 1'b0};
        tbl[5] = '{4'b0100, 16'h50A7, -1, 0,  0, 2, 0,  3,  1'b1};
        tbl[6] = '{4'b0010, 16'h1248, -1, 0,  4, 1, 4,  7,  1'b1};
        tbl[7] = '{4'b0001, 16'h9993,  0, 2, -1, 0, 3,  8,  1'b0};
        tbl[8] = '{4'b1010, 16'h7E21, -1, 0, -1, 1, 2,  5,  1'b0};
        tbl[9] = '{4'b1010, 16'h7E21, -1, 0, -1, 3, 7,  10, 1'b0};

        // reset held with every requester active: nothing may be granted
        uba_req = 4'b1111;
        uba_len = 16'h2222;
        for (int c = 0; c < 4; c++) begin
            @(posedge uba_clk);
            #2;
            chk("rst_gnt", uba_gnt, 0);
            chk("rst_cnt_en", uba_cnt_en, 0);
            chk("rst_busy", uba_busy, 0);
            chk("rst_cnt_rst", uba_cnt_rst, 1);
        end
        uba_rst = 1'b0;

        // round robin with all requesters active, starting at requester 0
        for (int b = 0; b < 5; b++) begin
            v = '{4'b1111, 16'h2222, -1, 0, -1, rr_pick(4'b1111, last_g), 2, 5, 1'b0};
            chk("rr_order", v.exp_g, (b % N));
            apply_vec($sformatf("rr%0d", b), v);
        end

        for (int t = 0; t < 10; t++) begin
            apply_vec($sformatf("vec%0d", t), tbl[t]);
        end

        // reset in the middle of RUN: immediate idle, no completion or abort pulse
        uba_req = 4'b0001;
        uba_len = 16'h0006;
        n_en = 0;
        for (int c = 0; c < 20 && n_en < 2; c++) begin
            @(posedge uba_clk);
            #1;
            if (uba_cnt_en) n_en++;
        end
        chk("mid_rst_en_seen", n_en, 2);
        @(posedge uba_clk);
        #1;
        chk("mid_rst_busy_before", uba_busy, 1);
        uba_rst = 1'b1;
        #1;
        chk("mid_rst_gnt", uba_gnt, 0);
        chk("mid_rst_busy", uba_busy, 0);
        chk("mid_rst_cnt_en", uba_cnt_en, 0);
        chk("mid_rst_cnt_rst", uba_cnt_rst, 1);
        chk("mid_rst_pulses", {uba_done, uba_abrt}, 0);
        @(posedge uba_clk);
        #2;
        uba_rst = 1'b0;
        uba_req = '0;
        last_g  = N - 1;
        acc_pulse = '0;
        acc_busy  = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge uba_clk);
            #2;
            acc_pulse = acc_pulse | uba_done | uba_abrt;
            if (uba_busy) acc_busy++;
        end
        chk("post_rst_pulses", acc_pulse, 0);
        chk("post_rst_busy", acc_busy, 0);

        // randomized bursts against the transaction-level model
        for (int r = 0; r < 40; r++) begin
            logic [N-1:0] rq;
            logic [N*W-1:0] ln;
            int g, L, mode;
            rq = N'($urandom_range(1, (1 << N) - 1));
            ln = (N*W)'($urandom);
            g  = rr_pick(rq, last_g);
            L  = int'(ln[g*W +: W]);
            mode = $urandom_range(0, 2);
            v = '{rq, ln, -1, 0, -1, g, L, L + 3, 1'b0};
            if (mode == 1 && L >= 1) begin
                v.hold_after = $urandom_range(0, L - 1);
                v.hold_cyc   = $urandom_range(1, 5);
                v.exp_busy   = L + 3 + v.hold_cyc;
            end else if (mode == 2) begin
                v.abort_after = $urandom_range(0, L);
                v.exp_en      = v.abort_after;
                v.exp_busy    = v.abort_after + 3;
                v.exp_abrt    = 1'b1;
            end
            apply_vec($sformatf("rnd%0d", r), v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
